dbg_guv_ctrl: RTL and testbench
===============================

# dbg_guv_ctrl

Control FSM that sits directly upstream of the debug-governor datapath. It accepts 27-bit debug commands on an AXI-Stream-style command port and decodes them. It then drives the datapath's `state_next` encoding through START, action, WAIT and DONE states. It consumes the datapath's DONE acknowledgements, so the datapath no longer needs an externally sequenced state.

## Interface
Parameters:
- `CMD_WIDTH`, 27: command word width; fields are data [26:11], op one-hot [10:1], continuous [0].
- `DATA_W`, 16: data-field width; serves as inject payload or action duration.
- `STATE_W`, 10: width of `state_next`.

Ports:
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_in_TDATA`  in  27  command word.
- `cmd_in_TVALID`  in  1  command valid.
- `cmd_in_TREADY`  out  1  command accepted when `TVALID & TREADY` at a rising edge of `clk`.
- `done_DONE_DROP`, `done_DONE_INJECT`, `done_DONE_LOG`, `done_DONE_PAUSE`  in  1 each  datapath cleanup-complete acknowledgements.
- `state_next`  out  10  encoded state, zero-extended: START=0, DROP=1, INJECT=2, WAIT=3, LOG=4, PAUSE=5, DONE_DROP=6, DONE_LOG=7, DONE_INJECT=8, DONE_PAUSE=9.
- `cmd_data`  out  16  data field of the active command.
- `cont_enable`  out  1  continuous bit of the active command.
- `busy`  out  1  high whenever the state is not START.

## Operation
- Decode: k = lowest set index of op[9:0].
  - k∈{0,1} → PAUSE; {2,3} → DROP; {4,5} → INJECT; {6..9} → LOG.
  - op==0 is a no-op: the word is accepted, discarded, and the state stays START.
  - If several op bits are set, the lowest index wins.
- START: `TREADY`=1. On accept, latch data and continuous bit into `cmd_data` and `cont_enable`, then go to the decoded action.
- INJECT: always lasts 1 cycle, then goes to DONE_INJECT (no WAIT). `cmd_data` carries the payload.
- DROP/LOG/PAUSE, non-continuous:
  - `TREADY`=0.
  - A 16-bit down-counter is loaded with max(data,1) and decremented each cycle in the action state.
  - At count 1, go to WAIT.
- DROP/LOG/PAUSE, continuous:
  - `TREADY`=1 and the counter is ignored.
  - The action persists until the next accepted command.
  - That command is stored in a one-entry pending register (op==0 words still terminate the action, but are not stored). The FSM then goes to WAIT.
- WAIT: lasts 1 cycle, `TREADY`=0. Then goes to DONE_x matching the action just ended.
- DONE_x: `TREADY`=0. Holds until the matching `done_DONE_x`=1.
  - If the pending register is valid, go directly to its action and clear pending.
  - Otherwise go to START.
  - `done_*` inputs for non-matching states are ignored.
- `TVALID` asserted while `TREADY`=0: the word is held by the source and not consumed.

## Timing
- All outputs are registered.
- Reset values: `state_next`=0, `cmd_in_TREADY`=0, `cmd_data`=0, `cont_enable`=0, `busy`=0; pending register cleared.
- `TREADY` rises in the first cycle after reset deasserts.
- Accept at edge T: `state_next` = action from T+1.
- Non-continuous action with data=N: action state for N cycles (1 if N=0), WAIT for 1 cycle, then DONE_x.
- DONE_x exits on the edge where the matching ack is sampled high. Minimum DONE_x duration is 1 cycle.
- Asserting `rst` mid-operation forces START immediately (asynchronous). Any pending command is lost.
- Acceptance in START and in a continuous action state are the only two points where a handshake completes.

## Structure
- `dbg_guv_pkg` holds:
  - the state enum and its encoding (0..9);
  - command field positions (`DATA_MSB`/`LSB`, `OP_MSB`/`LSB`, `CONT_BIT`);
  - the function `decode_op(op) → state`.
- One sub-module is natural: `dbg_guv_cmd_decode`, purely combinational. It takes the command word and returns target state, data, cont and valid-op.
- The FSM, counter and pending register live in `dbg_guv_ctrl`.

## Test plan
- Reset with `cmd_in_TVALID`=1 → `state_next`=0 and `TREADY`=0 while `rst`=0. Release reset → word accepted on the first edge where `TREADY`=1.
- Command data=3, op bit 3, cont=0 → DROP(1) for 3 cycles, WAIT(3) for 1 cycle, DONE_DROP(6) until `done_DONE_DROP`, then 0. `TREADY`=0 throughout.
- Command data=0x5555, op bit 5 → INJECT(2) for 1 cycle with `cmd_data`=0x5555, then DONE_INJECT(8). Ack delayed 4 cycles → remains 8 for 4 cycles.
- Command op bit 7, cont=1, followed 10 cycles later by op bit 0 → LOG(4) for 10 cycles, WAIT, DONE_LOG(7), ack, then PAUSE(5) directly without visiting 0.
- Command op=0 → accepted, `state_next` stays 0. Op=0b1000001100 → DROP (index 2 wins). Data=0 non-continuous → action lasts 1 cycle.
- `rst` asserted mid-DROP and mid-DONE_PAUSE → `state_next`=0 with no clock edge. The pending command is not executed after release.

Source files
------------

// File: rtl/dbg_guv_pkg.sv
// rtl/dbg_guv_pkg.sv - debug-governor state encoding, command fields and decode helpers
package dbg_guv_pkg;

  typedef enum logic [3:0] {
    ST_START       = 4'd0,
    ST_DROP        = 4'd1,
    ST_INJECT      = 4'd2,
    ST_WAIT        = 4'd3,
    ST_LOG         = 4'd4,
    ST_PAUSE       = 4'd5,
    ST_DONE_DROP   = 4'd6,
    ST_DONE_LOG    = 4'd7,
    ST_DONE_INJECT = 4'd8,
    ST_DONE_PAUSE  = 4'd9
  } state_t;

  localparam int DATA_MSB = 26;
  localparam int DATA_LSB = 11;
  localparam int OP_MSB   = 10;
  localparam int OP_LSB   = 1;
  localparam int CONT_BIT = 0;
  localparam int OP_W     = OP_MSB - OP_LSB + 1;

  // Scanning from the top down lets the lowest set bit have the last word.
  function automatic state_t decode_op(input logic [OP_W-1:0] op);
    state_t s;
    s = ST_START;
    for (int i = OP_W - 1; i >= 0; i--) begin
      if (op[i]) begin
        if (i < 2)      s = ST_PAUSE;
        else if (i < 4) s = ST_DROP;
        else if (i < 6) s = ST_INJECT;
        else            s = ST_LOG;
      end
    end
    return s;
  endfunction

  function automatic state_t done_of(input state_t a);
    case (a)
      ST_DROP:   return ST_DONE_DROP;
      ST_LOG:    return ST_DONE_LOG;
      ST_INJECT: return ST_DONE_INJECT;
      ST_PAUSE:  return ST_DONE_PAUSE;
      default:   return ST_START;
    endcase
  endfunction

  function automatic logic is_timed(input state_t s);
    return (s == ST_DROP) || (s == ST_LOG) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/dbg_guv_cmd_decode.sv
// rtl/dbg_guv_cmd_decode.sv - splits a command word into target state, data and continuous bit
module dbg_guv_cmd_decode
  import dbg_guv_pkg::*;
#(
  parameter int CMD_WIDTH = 27,
  parameter int DATA_W    = 16
) (
  input  logic [CMD_WIDTH-1:0] cmd,
  output logic [3:0]           target,
  output logic [DATA_W-1:0]    data,
  output logic                 cont,
  output logic                 op_valid
);

  assign data     = cmd[DATA_MSB:DATA_LSB];
  assign cont     = cmd[CONT_BIT];
  assign op_valid = |cmd[OP_MSB:OP_LSB];
  assign target   = decode_op(cmd[OP_MSB:OP_LSB]);

endmodule

// File: rtl/dbg_guv_ctrl.sv
// rtl/dbg_guv_ctrl.sv - command-driven state sequencer feeding the debug-governor datapath
module dbg_guv_ctrl
  import dbg_guv_pkg::*;
#(
  parameter int CMD_WIDTH = 27,
  parameter int DATA_W    = 16,
  parameter int STATE_W   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CMD_WIDTH-1:0] cmd_in_TDATA,
  input  logic                 cmd_in_TVALID,
  output logic                 cmd_in_TREADY,
  input  logic                 done_DONE_DROP,
  input  logic                 done_DONE_INJECT,
  input  logic                 done_DONE_LOG,
  input  logic                 done_DONE_PAUSE,
  output logic [STATE_W-1:0]   state_next,
  output logic [DATA_W-1:0]    cmd_data,
  output logic                 cont_enable,
  output logic                 busy
);

  state_t              state, nxt, act, nxt_act, dec_state;
  logic [3:0]          dec_target;
  logic [DATA_W-1:0]   dec_data, cnt, nxt_cnt, nxt_data;
  logic                dec_cont, dec_valid, nxt_cont, nxt_tready, hs, ack_hit;

  state_t              pend_state, nxt_pend_state;
  logic [DATA_W-1:0]   pend_data, nxt_pend_data;
  logic                pend_cont, nxt_pend_cont, pend_valid, nxt_pend_valid;

  dbg_guv_cmd_decode #(
    .CMD_WIDTH (CMD_WIDTH),
    .DATA_W    (DATA_W)
  ) u_decode (
    .cmd      (cmd_in_TDATA),
    .target   (dec_target),
    .data     (dec_data),
    .cont     (dec_cont),
    .op_valid (dec_valid)
  );

  assign dec_state = state_t'(dec_target);
  assign hs        = cmd_in_TVALID & cmd_in_TREADY;

  always_comb begin
    ack_hit = 1'b0;
    case (state)
      ST_DONE_DROP:   ack_hit = done_DONE_DROP;
      ST_DONE_LOG:    ack_hit = done_DONE_LOG;
      ST_DONE_INJECT: ack_hit = done_DONE_INJECT;
      ST_DONE_PAUSE:  ack_hit = done_DONE_PAUSE;
      default:        ack_hit = 1'b0;
    endcase
  end

  // A zero duration still spends one cycle in the action state.
  function automatic logic [DATA_W-1:0] load_cnt(input logic [DATA_W-1:0] d);
    return (d == '0) ? DATA_W'(1) : d;
  endfunction

  always_comb begin
    nxt            = state;
    nxt_act        = act;
    nxt_data       = cmd_data;
    nxt_cont       = cont_enable;
    nxt_cnt        = cnt;
    nxt_pend_valid = pend_valid;
    nxt_pend_state = pend_state;
    nxt_pend_data  = pend_data;
    nxt_pend_cont  = pend_cont;
    case (state)
      ST_START: begin
        if (hs && dec_valid) begin
          nxt      = dec_state;
          nxt_act  = dec_state;
          nxt_data = dec_data;
          nxt_cont = dec_cont;
          nxt_cnt  = load_cnt(dec_data);
        end
      end
      ST_DROP, ST_LOG, ST_PAUSE: begin
        if (cont_enable) begin
          if (hs) begin
            nxt = ST_WAIT;
            // A no-op word ends the action but is not worth replaying.
            if (dec_valid) begin
              nxt_pend_valid = 1'b1;
              nxt_pend_state = dec_state;
              nxt_pend_data  = dec_data;
              nxt_pend_cont  = dec_cont;
            end
          end
        end else if (cnt <= DATA_W'(1)) begin
          nxt = ST_WAIT;
        end else begin
          nxt_cnt = cnt - DATA_W'(1);
        end
      end
      ST_INJECT: nxt = ST_DONE_INJECT;
      ST_WAIT:   nxt = done_of(act);
      ST_DONE_DROP, ST_DONE_LOG, ST_DONE_INJECT, ST_DONE_PAUSE: begin
        if (ack_hit) begin
          if (pend_valid) begin
            nxt            = pend_state;
            nxt_act        = pend_state;
            nxt_data       = pend_data;
            nxt_cont       = pend_cont;
            nxt_cnt        = load_cnt(pend_data);
            nxt_pend_valid = 1'b0;
          end else begin
            nxt = ST_START;
          end
        end
      end
      default: nxt = ST_START;
    endcase
  end

  assign nxt_tready = (nxt == ST_START) || (is_timed(nxt) && nxt_cont);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_START;
      act           <= ST_START;
      cnt           <= '0;
      pend_valid    <= 1'b0;
      pend_state    <= ST_START;
      pend_data     <= '0;
      pend_cont     <= 1'b0;
      state_next    <= '0;
      cmd_in_TREADY <= 1'b0;
      cmd_data      <= '0;
      cont_enable   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= nxt;
      act           <= nxt_act;
      cnt           <= nxt_cnt;
      pend_valid    <= nxt_pend_valid;
      pend_state    <= nxt_pend_state;
      pend_data     <= nxt_pend_data;
      pend_cont     <= nxt_pend_cont;
      state_next    <= {{(STATE_W-4){1'b0}}, nxt};
      cmd_in_TREADY <= nxt_tready;
      cmd_data      <= nxt_data;
      cont_enable   <= nxt_cont;
      busy          <= (nxt != ST_START);
    end
  end

endmodule

// File: tb/tb_dbg_guv_ctrl.sv
// tb/tb_dbg_guv_ctrl.sv - directed scoreboard bench for dbg_guv_ctrl
module tb_dbg_guv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] tdata;
  logic        tvalid, tready;
  logic        d_drop, d_inject, d_log, d_pause;
  logic [9:0]  state_next;
  logic [15:0] cmd_data;
  logic        cont_enable, busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int    st;
    bit    rdy;
    string tag;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dbg_guv_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_in_TDATA     (tdata),
    .cmd_in_TVALID    (tvalid),
    .cmd_in_TREADY    (tready),
    .done_DONE_DROP   (d_drop),
    .done_DONE_INJECT (d_inject),
    .done_DONE_LOG    (d_log),
    .done_DONE_PAUSE  (d_pause),
    .state_next       (state_next),
    .cmd_data         (cmd_data),
    .cont_enable      (cont_enable),
    .busy             (busy)
  );

  function automatic logic [26:0] mk(input logic [15:0] d, input logic [9:0] op, input logic c);
    return {d, op, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expectation is queued before the edge and retired once the DUT has produced it.
  task automatic cyc(input string tag, input int st, input bit rdy);
    exp_t e;
    exp_q.push_back('{st: st, rdy: rdy, tag: tag});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, ".state"}, {22'd0, state_next}, e.st);
    chk({e.tag, ".ready"}, {31'd0, tready}, {31'd0, e.rdy});
    chk({e.tag, ".busy"}, {31'd0, busy}, {31'd0, (e.st != 0)});
  endtask

  initial begin
    rst      = 1'b0;
    tvalid   = 1'b1;
    tdata    = mk(16'd3, 10'b0000001000, 1'b0);
    d_drop   = 1'b0;
    d_inject = 1'b0;
    d_log    = 1'b0;
    d_pause  = 1'b0;

    #12;
    chk("rst.state", {22'd0, state_next}, 0);
    chk("rst.ready", {31'd0, tready}, 0);
    chk("rst.busy", {31'd0, busy}, 0);
    chk("rst.data", {16'd0, cmd_data}, 0);
    chk("rst.cont", {31'd0, cont_enable}, 0);
    @(posedge clk);
    #1;
    chk("rst_edge.ready", {31'd0, tready}, 0);
    rst = 1'b1;

    cyc("release", 0, 1'b1);
    cyc("drop_c1", 1, 1'b0);
    chk("drop.data", {16'd0, cmd_data}, 32'd3);
    chk("drop.cont", {31'd0, cont_enable}, 0);
    tvalid = 1'b0;
    cyc("drop_c2", 1, 1'b0);
    cyc("drop_c3", 1, 1'b0);
    cyc("drop_wait", 3, 1'b0);
    cyc("drop_done1", 6, 1'b0);
    cyc("drop_done2", 6, 1'b0);
    d_drop = 1'b1;
    cyc("drop_exit", 0, 1'b1);
    d_drop = 1'b0;

    tvalid = 1'b1;
    tdata  = mk(16'h5555, 10'b0000100000, 1'b0);
    cyc("inj", 2, 1'b0);
    chk("inj.data", {16'd0, cmd_data}, 32'h5555);
    tvalid = 1'b0;
    cyc("inj_done1", 8, 1'b0);
    d_drop = 1'b1;
    cyc("inj_done2", 8, 1'b0);
    cyc("inj_done3", 8, 1'b0);
    cyc("inj_done4", 8, 1'b0);
    d_drop   = 1'b0;
    d_inject = 1'b1;
    cyc("inj_exit", 0, 1'b1);
    d_inject = 1'b0;

    tvalid = 1'b1;
    tdata  = mk(16'h00aa, 10'b0010000000, 1'b1);
    cyc("log_c1", 4, 1'b1);
    chk("log.cont", {31'd0, cont_enable}, 1);
    tvalid = 1'b0;
    for (int i = 0; i < 9; i++) cyc("log_hold", 4, 1'b1);
    tvalid = 1'b1;
    tdata  = mk(16'd2, 10'b0000000001, 1'b0);
    cyc("log_wait", 3, 1'b0);
    tvalid = 1'b0;
    cyc("log_done", 7, 1'b0);
    d_log = 1'b1;
    cyc("pend_pause1", 5, 1'b0);
    chk("pend.data", {16'd0, cmd_data}, 32'd2);
    chk("pend.cont", {31'd0, cont_enable}, 0);
    d_log = 1'b0;
    cyc("pend_pause2", 5, 1'b0);
    cyc("pause_wait", 3, 1'b0);
    cyc("pause_done", 9, 1'b0);
    d_pause = 1'b1;
    cyc("pause_exit", 0, 1'b1);
    d_pause = 1'b0;

    tvalid = 1'b1;
    tdata  = mk(16'h1234, 10'b0000000000, 1'b0);
    cyc("noop", 0, 1'b1);
    chk("noop.data", {16'd0, cmd_data}, 32'd2);
    tdata = mk(16'd0, 10'b1000001100, 1'b0);
    cyc("multi_drop", 1, 1'b0);
    tvalid = 1'b0;
    cyc("zero_wait", 3, 1'b0);
    cyc("zero_done", 6, 1'b0);
    d_drop = 1'b1;
    cyc("zero_exit", 0, 1'b1);
    d_drop = 1'b0;

    tvalid = 1'b1;
    tdata  = mk(16'd0, 10'b0000000100, 1'b1);
    cyc("cdrop", 1, 1'b1);
    tdata = mk(16'd7, 10'b0000000000, 1'b0);
    cyc("cdrop_wait", 3, 1'b0);
    tvalid = 1'b0;
    cyc("cdrop_done", 6, 1'b0);
    d_drop = 1'b1;
    cyc("cdrop_nopend", 0, 1'b1);
    d_drop = 1'b0;

    tvalid = 1'b1;
    tdata  = mk(16'd5, 10'b0000000100, 1'b0);
    cyc("rdrop1", 1, 1'b0);
    tvalid = 1'b0;
    cyc("rdrop2", 1, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("async_drop.state", {22'd0, state_next}, 0);
    chk("async_drop.ready", {31'd0, tready}, 0);
    #2 rst = 1'b1;
    cyc("rdrop_rel", 0, 1'b1);

    tvalid = 1'b1;
    tdata  = mk(16'd0, 10'b0000000001, 1'b1);
    cyc("rpause", 5, 1'b1);
    tdata = mk(16'd2, 10'b0000001000, 1'b0);
    cyc("rpause_wait", 3, 1'b0);
    tvalid = 1'b0;
    cyc("rpause_done", 9, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("async_done.state", {22'd0, state_next}, 0);
    chk("async_done.busy", {31'd0, busy}, 0);
    #2 rst = 1'b1;
    d_pause = 1'b1;
    cyc("nopend1", 0, 1'b1);
    cyc("nopend2", 0, 1'b1);
    d_pause = 1'b0;
    cyc("nopend3", 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
